ram_ctrl: RTL

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/ram_ctrl.sv
// Single-port RAM controller: serialises client reads/writes onto a shared
// tristate RAM bus and can sweep the whole array to zero on request.
module ram_ctrl #(
   parameter int width      = 8,
   parameter int depth      = 256,
   parameter int addr_width = $clog2(depth)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [addr_width-1:0] req_addr,
   input  logic [width-1:0]      req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [width-1:0]      rsp_rdata,
   input  logic                  clear_start,
   output logic                  busy,
   output logic                  clear_done,
   inout  wire  [width-1:0]      ram_data,
   output logic [addr_width-1:0] ram_addr,
   output logic                  ram_read,
   output logic                  ram_write,
   output logic                  ram_reset
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] WR   = 3'd1;
   localparam logic [2:0] RD   = 3'd2;
   localparam logic [2:0] RSP  = 3'd3;
   localparam logic [2:0] CLR  = 3'd4;

   localparam logic [addr_width-1:0] last_addr = addr_width'(depth - 1);

   logic [2:0]            state;
   logic [addr_width-1:0] counter;
   logic [addr_width-1:0] addr_q;
   logic [width-1:0]      wdata_q;
   logic                  accept;

   // A pending clear blocks acceptance so the request waits out the sweep.
   assign req_ready = (state == IDLE) && !clear_start;
   assign accept    = req_ready && req_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         counter    <= '0;
         rsp_rdata  <= '0;
         clear_done <= 1'b0;
      end else begin
         clear_done <= 1'b0;
         case (state)
            IDLE: begin
               if (clear_start) begin
                  state   <= CLR;
                  counter <= '0;
               end else if (req_valid) begin
                  state <= req_write ? WR : RD;
               end
            end
            WR:  state <= IDLE;
            RD: begin
               rsp_rdata <= ram_data;
               state     <= RSP;
            end
            RSP: begin
               if (rsp_ready) state <= IDLE;
            end
            CLR: begin
               counter <= counter + 1'b1;
               if (counter == last_addr) begin
                  state      <= IDLE;
                  counter    <= '0;
                  clear_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Request payload is only meaningful once accepted, so it needs no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   always_comb begin
      ram_addr = '0;
      case (state)
         WR, RD:  ram_addr = addr_q;
         CLR:     ram_addr = counter;
         default: ram_addr = '0;
      endcase
   end

   assign busy      = (state != IDLE);
   assign rsp_valid = (state == RSP);
   assign ram_write = (state == WR);
   assign ram_read  = (state == RD);
   assign ram_reset = (state == CLR);

   assign ram_data = ram_write ? wdata_q : {width{1'bz}};

endmodule
